// File: rtl/dpwm_duty_decoder.sv
// Duty-cycle code decoder for the HR-DPWM high-side path: double-buffers
// start/stop codes, splits them into coarse/fine fields and sequences periods.
module dpwm_duty_decoder #(
  parameter int unsigned Nde          = 64,
  parameter int unsigned DE_bits      = 6,
  parameter int unsigned Dc_length    = 13,
  parameter int unsigned Count_length = Dc_length - DE_bits,
  parameter int unsigned Period_len   = 128,
  parameter int unsigned Enable_len   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    duty_valid,
  output logic                    duty_ready,
  input  logic [Dc_length-1:0]    duty_start_code,
  input  logic [Dc_length-1:0]    duty_stop_code,
  output logic [Count_length:0]   start_coarse,
  output logic [DE_bits-1:0]      start_fine,
  output logic [Count_length:0]   stop_coarse,
  output logic [DE_bits-1:0]      stop_fine,
  output logic                    enable_h,
  output logic                    period_start,
  output logic                    cfg_err
);

  localparam int unsigned CW = (Period_len > 1) ? $clog2(Period_len) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, COUNT} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   enter_clear;
  logic                   pend_full;
  logic                   active_valid;
  logic [Dc_length-1:0]   pend_start, pend_stop;

  logic                   accept;
  logic                   stop_lt;
  logic [Dc_length-1:0]   stop_ord;
  logic [DE_bits-1:0]     start_fine_fix, stop_fine_fix;
  logic                   clamp_hit;

  assign duty_ready = !pend_full;
  assign accept     = duty_valid && !pend_full;
  // Ordering is fixed on the raw codes first; clamping afterwards keeps a
  // forced stop identical to the start.
  assign stop_lt    = duty_stop_code < duty_start_code;
  assign stop_ord   = stop_lt ? duty_start_code : duty_stop_code;

  generate
    if (Nde < (1 << DE_bits)) begin : g_clamp
      localparam logic [DE_bits-1:0] FINE_MAX = DE_bits'(Nde - 1);
      always_comb begin
        start_fine_fix = duty_start_code[DE_bits-1:0];
        stop_fine_fix  = stop_ord[DE_bits-1:0];
        clamp_hit      = 1'b0;
        if (start_fine_fix > FINE_MAX) begin
          start_fine_fix = FINE_MAX;
          clamp_hit      = 1'b1;
        end
        if (stop_fine_fix > FINE_MAX) begin
          stop_fine_fix = FINE_MAX;
          clamp_hit     = 1'b1;
        end
      end
    end else begin : g_noclamp
      assign start_fine_fix = duty_start_code[DE_bits-1:0];
      assign stop_fine_fix  = stop_ord[DE_bits-1:0];
      assign clamp_hit      = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    enter_clear = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (run && (active_valid || pend_full)) begin
          state_nxt   = CLEAR;
          enter_clear = 1'b1;
        end
      end
      CLEAR: begin
        if (!run) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(Enable_len - 1)) state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(Period_len - 1)) begin
          state_nxt   = CLEAR;
          enter_clear = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pend_full    <= 1'b0;
      active_valid <= 1'b0;
      pend_start   <= '0;
      pend_stop    <= '0;
      start_coarse <= '0;
      start_fine   <= '0;
      stop_coarse  <= '0;
      stop_fine    <= '0;
      enable_h     <= 1'b1;
      period_start <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      enable_h     <= (state_nxt != COUNT);
      period_start <= enter_clear;
      cfg_err      <= accept && (stop_lt || clamp_hit);
      // Accept and transfer are exclusive: accept needs an empty pending slot.
      if (accept) begin
        pend_start <= {duty_start_code[Dc_length-1:DE_bits], start_fine_fix};
        pend_stop  <= {stop_ord[Dc_length-1:DE_bits], stop_fine_fix};
        pend_full  <= 1'b1;
      end else if (enter_clear && pend_full) begin
        pend_full  <= 1'b0;
      end
      if (enter_clear && pend_full) begin
        start_coarse <= {1'b0, pend_start[Dc_length-1:DE_bits]};
        start_fine   <= pend_start[DE_bits-1:0];
        stop_coarse  <= {1'b0, pend_stop[Dc_length-1:DE_bits]};
        stop_fine    <= pend_stop[DE_bits-1:0];
        active_valid <= 1'b1;
      end
    end
  end

endmodule
